// File: rtl/ascii_operand_parser.sv
// Console front end: parses "X\nY\n<op>\n" ASCII frames into two 5-bit operands
// and an add/subtract select, reporting malformed input with a one-cycle error pulse.
module ascii_operand_parser #(
    parameter logic [7:0] NL_CHAR = 8'h0A,
    parameter int         MAX_VAL = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [4:0] x,
    output logic [4:0] y,
    output logic       sub,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {GET_X, GET_Y, GET_OP, OP_NL, HOLD, FLUSH} state_t;

    localparam logic [7:0] CR_CHAR    = 8'h0D;
    localparam logic [7:0] PLUS_CHAR  = 8'h2B;
    localparam logic [7:0] MINUS_CHAR = 8'h2D;

    localparam logic [1:0] ERR_BAD_CHAR  = 2'd0;
    localparam logic [1:0] ERR_RANGE     = 2'd1;
    localparam logic [1:0] ERR_EMPTY     = 2'd2;
    localparam logic [1:0] ERR_TOO_LONG  = 2'd3;

    state_t     state_reg, state_next;
    logic [6:0] acc_reg, acc_next;
    logic [1:0] cnt_reg, cnt_next;
    logic [4:0] x_reg, x_next;
    logic [4:0] y_reg, y_next;
    logic       sub_reg, sub_next;
    logic       err_reg, err_next;
    logic [1:0] err_code_reg, err_code_next;

    logic       fire;
    logic       is_digit;
    logic       is_nl;
    logic [6:0] acc_dec;
    logic       raise;
    logic [1:0] raise_code;

    assign in_ready  = (state_reg != HOLD);
    assign out_valid = (state_reg == HOLD);
    assign x         = x_reg;
    assign y         = y_reg;
    assign sub       = sub_reg;
    assign err       = err_reg;
    assign err_code  = err_code_reg;

    assign fire     = in_valid && in_ready;
    assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign is_nl    = (in_data == NL_CHAR);
    // Two decimal digits top out at 99, so the 7-bit accumulator never wraps.
    assign acc_dec  = acc_reg * 7'd10 + {3'b000, in_data[3:0]};

    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        cnt_next      = cnt_reg;
        x_next        = x_reg;
        y_next        = y_reg;
        sub_next      = sub_reg;
        err_next      = 1'b0;
        err_code_next = err_code_reg;
        raise         = 1'b0;
        raise_code    = ERR_BAD_CHAR;

        if (fire && in_data != CR_CHAR) begin
            case (state_reg)
                GET_X, GET_Y: begin
                    if (is_digit) begin
                        if (cnt_reg == 2'd2) begin
                            raise      = 1'b1;
                            raise_code = ERR_TOO_LONG;
                        end else begin
                            acc_next = acc_dec;
                            cnt_next = cnt_reg + 2'd1;
                        end
                    end else if (is_nl) begin
                        if (cnt_reg == 2'd0) begin
                            raise      = 1'b1;
                            raise_code = ERR_EMPTY;
                        end else if (acc_reg > 7'(MAX_VAL)) begin
                            raise      = 1'b1;
                            raise_code = ERR_RANGE;
                        end else begin
                            if (state_reg == GET_X) begin
                                x_next     = acc_reg[4:0];
                                state_next = GET_Y;
                            end else begin
                                y_next     = acc_reg[4:0];
                                state_next = GET_OP;
                            end
                            acc_next = '0;
                            cnt_next = '0;
                        end
                    end else begin
                        raise = 1'b1;
                    end
                end
                GET_OP: begin
                    if (in_data == PLUS_CHAR) begin
                        sub_next   = 1'b0;
                        state_next = OP_NL;
                    end else if (in_data == MINUS_CHAR) begin
                        sub_next   = 1'b1;
                        state_next = OP_NL;
                    end else begin
                        raise = 1'b1;
                    end
                end
                OP_NL: begin
                    if (is_nl) begin
                        state_next = HOLD;
                    end else begin
                        raise = 1'b1;
                    end
                end
                FLUSH: begin
                    if (is_nl) begin
                        state_next = GET_X;
                    end
                end
                default: begin
                end
            endcase
        end

        if (state_reg == HOLD && out_ready) begin
            state_next = GET_X;
        end

        // A bad terminator already ends the frame; anything else must be flushed.
        if (raise) begin
            err_next      = 1'b1;
            err_code_next = raise_code;
            acc_next      = '0;
            cnt_next      = '0;
            state_next    = is_nl ? GET_X : FLUSH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= GET_X;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            sub_reg      <= 1'b0;
            err_reg      <= 1'b0;
            err_code_reg <= '0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            cnt_reg      <= cnt_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            sub_reg      <= sub_next;
            err_reg      <= err_next;
            err_code_reg <= err_code_next;
        end
    end

endmodule

// File: tb/tb_ascii_operand_parser.sv
// Directed bench for ascii_operand_parser: expected requests and error codes are
// queued as the frames are sent and checked when the parser produces them.
module tb_ascii_operand_parser;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] x;
    logic [4:0] y;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic       err;
    logic [1:0] err_code;

    int checks = 0;
    int fails  = 0;

    logic [10:0] exp_req_q[$];
    logic [1:0]  exp_err_q[$];

    ascii_operand_parser dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard side: compare requests and error pulses as they appear.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                checks++;
                assert (exp_req_q.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_req observed=%0h expected=none", {x, y, sub});
                end
                if (exp_req_q.size() != 0) begin
                    logic [10:0] e;
                    e = exp_req_q.pop_front();
                    checks++;
                    assert ({x, y, sub} === e) else begin
                        fails++;
                        $error("FAIL req observed x=%0d y=%0d sub=%0d expected x=%0d y=%0d sub=%0d",
                               x, y, sub, e[10:6], e[5:1], e[0]);
                    end
                    $display("req   x=%0d y=%0d sub=%0d", x, y, sub);
                end
            end
            if (err) begin
                checks++;
                assert (exp_err_q.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_err observed=%0d expected=none", err_code);
                end
                if (exp_err_q.size() != 0) begin
                    logic [1:0] ec;
                    ec = exp_err_q.pop_front();
                    checks++;
                    assert (err_code === ec) else begin
                        fails++;
                        $error("FAIL err_code observed=%0d expected=%0d", err_code, ec);
                    end
                    $display("err   code=%0d", err_code);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int waited;
        in_data  = b;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $error("FAIL in_ready_timeout observed=0 expected=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    task automatic push_req(input logic [4:0] ex, input logic [4:0] ey, input logic es);
        exp_req_q.push_back({ex, ey, es});
    endtask

    initial begin
        logic [10:0] held;
        reset     = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_sub", 32'(sub), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic frame; request valid the cycle after the operator terminator.
        push_req(5'd12, 5'd5, 1'b0);
        send_str("12\n05\n+\n");
        check("lat_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        check("one_cycle_out_valid", 32'(out_valid), 32'd0);

        // CR tolerated, boundary value 31.
        push_req(5'd31, 5'd1, 1'b1);
        send_str("31\n1\r\n-\n");

        // Range error then recovery.
        exp_err_q.push_back(2'd1);
        push_req(5'd7, 5'd3, 1'b0);
        send_str("32\n07\n03\n+\n");

        // Bad char, flush, recovery, then empty fields.
        exp_err_q.push_back(2'd0);
        push_req(5'd9, 5'd9, 1'b1);
        send_str("1a5\n9\n9\n-\n");
        exp_err_q.push_back(2'd2);
        exp_err_q.push_back(2'd2);
        send_str("\n\n");
        check("err_code_holds", 32'(err_code), 32'd2);

        // Back-pressure in HOLD.
        out_ready = 1'b0;
        push_req(5'd20, 5'd11, 1'b1);
        send_str("20\n11\n-\n");
        held = {x, y, sub};
        check("hold_entry_x", 32'(x), 32'd20);
        for (int i = 0; i < 5; i++) begin
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_stable", 32'({x, y, sub}), 32'(held));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_out_valid", 32'(out_valid), 32'd0);
        check("hold_release_in_ready", 32'(in_ready), 32'd1);

        // Reset mid-frame with a byte presented during reset.
        send_str("1");
        in_data  = "9";
        in_valid = 1'b1;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        check("midrst_x", 32'(x), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        push_req(5'd4, 5'd2, 1'b0);
        send_str("4\n2\n+\n");

        // Too many digits.
        exp_err_q.push_back(2'd3);
        send_str("123\n");
        check("too_long_code", 32'(err_code), 32'd3);

        repeat (4) @(posedge clk);
        #1;
        check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
        check("err_queue_drained", 32'(exp_err_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ascii_operand_parser.md
ASCII_OPERAND_PARSER -- requirements
Module: ascii_operand_parser

Interface
REQ-001 SHALL have parameter NL_CHAR, default 8'h0A, which is the field terminator byte.
REQ-002 SHALL have parameter MAX_VAL, default 31, which is the largest legal operand value (5-bit).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_data, input, 8 bits: ASCII byte from the console stream.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the parser accepts a byte this cycle.
REQ-008 SHALL have port x, output, 5 bits: parsed operand X, unsigned.
REQ-009 SHALL have port y, output, 5 bits: parsed operand Y, unsigned.
REQ-010 SHALL have port sub, output, 1 bit: 1 for '-' and 0 for '+'; drives the downstream adder's C0.
REQ-011 SHALL have port out_valid, output, 1 bit: x/y/sub form a complete request.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream adder consumes the request.
REQ-013 SHALL have port err, output, 1 bit: one-cycle pulse on a parse error.
REQ-014 SHALL have port err_code, output, 2 bits: 0 = bad char, 1 = range, 2 = empty field, 3 = too many digits.

Function
REQ-015 SHALL accept a byte only on a rising edge with in_valid=1 and in_ready=1; no other byte is consumed.
REQ-016 SHALL use the FSM states GET_X, GET_Y, GET_OP, OP_NL, HOLD and FLUSH; in_ready SHALL be 1 in every state except HOLD, decoded combinationally from state.
REQ-017 SHALL silently drop accepted byte 8'h0D (CR) in every state, with no state change.
REQ-018 In GET_X and GET_Y, a digit 8'h30-8'h39 SHALL update acc <= acc*10 + (byte-8'h30) and increment cnt.
REQ-019 acc SHALL be 7 bits wide and cnt 2 bits wide.
REQ-020 A third digit in one field SHALL raise an error with code 3.
REQ-021 NL_CHAR in GET_X or GET_Y SHALL raise code 2 if cnt==0 and code 1 if acc>MAX_VAL.
REQ-022 Otherwise, NL_CHAR SHALL latch acc[4:0] into x (GET_X) or y (GET_Y), clear acc and cnt, and advance to GET_Y or GET_OP respectively.
REQ-023 In GET_OP, '+' (8'h2B) SHALL set sub=0 and '-' (8'h2D) SHALL set sub=1, then go to OP_NL; any other byte SHALL raise code 0.
REQ-024 In OP_NL, NL_CHAR SHALL go to HOLD; any other byte SHALL raise code 0.
REQ-025 Any other byte in GET_X or GET_Y SHALL raise code 0.
REQ-026 out_valid SHALL be 1 exactly while in HOLD, i.e. from the cycle after the operator's NL_CHAR is accepted (latency 1).
REQ-027 In HOLD, out_valid&out_ready SHALL return the FSM to GET_X, with out_valid=0 on the next cycle.
REQ-028 x, y and sub SHALL remain stable throughout HOLD.
REQ-029 x, y and sub SHALL hold their last values until overwritten by a later successful field.
REQ-030 On error, err=1 and err_code SHALL be valid for exactly the cycle after the offending byte is accepted; err_code SHALL hold its value afterwards.
REQ-031 On error, acc and cnt SHALL be cleared; the next state SHALL be GET_X if the offending byte was NL_CHAR and FLUSH otherwise.
REQ-032 FLUSH SHALL discard bytes until NL_CHAR is accepted, then go to GET_X; no err is raised in FLUSH.
REQ-033 reset SHALL take priority over a simultaneous handshake; the byte presented in a reset cycle is not consumed.

Reset
REQ-034 While reset=1 at a clock edge, the block SHALL load: state=GET_X, acc=0, cnt=0, x=0, y=0, sub=0, out_valid=0, err=0, err_code=0.
REQ-035 After reset, in_ready SHALL be 1.
REQ-036 Reset mid-frame SHALL discard all partial fields.

Verification
REQ-037 Stream "12\n05\n+\n" with out_ready=1 SHALL give out_valid=1 for one cycle with x=01100, y=00101, sub=0.
REQ-038 Stream "31\n1\r\n-\n" SHALL give x=11111, y=00001, sub=1, and err SHALL stay 0.
REQ-039 Stream "32\n07\n03\n+\n" SHALL give an err pulse with code 1 after "32\n", then a request x=7, y=3, sub=0.
REQ-040 Stream "1a5\n9\n9\n-\n" SHALL give err code 0 at 'a', flush through "\n", then a request x=9, y=9, sub=1; "\n\n" alone SHALL give err code 2.
REQ-041 Holding out_ready=0 for 5 cycles in HOLD SHALL keep in_ready=0, out_valid=1 and x/y/sub unchanged; raising out_ready SHALL complete the transfer.
REQ-042 Pulsing reset after "1" followed by "4\n2\n+\n" SHALL give x=4, not 14; "123\n" SHALL give err code 3 at '3'.
